// File: rtl/sr_ff_drv_pkg.sv
// Shared types and limits for the SR flip-flop command driver.
package sr_ff_drv_pkg;

   // Driver FSM states, 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PULSE  = 2'd1,
      SETTLE = 2'd2,
      CHECK  = 2'd3
   } state_t;

   localparam int CNT_W        = 4;
   localparam int PULSE_W_MAX  = 15;
   localparam int SETTLE_W_MAX = 15;

   // Clamp a phase width into 1..max so an out-of-range parameter cannot
   // produce a zero-length or wrapped phase.
   function automatic int clamp_width(input int w, input int max_w);
      if (w < 1)
         return 1;
      else if (w > max_w)
         return max_w;
      else
         return w;
   endfunction

   // The timer counts down to zero, so a phase of w cycles loads w-1.
   function automatic logic [CNT_W-1:0] phase_load(input int w);
      return CNT_W'(w - 1);
   endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter with zero flag; times the PULSE and SETTLE phases.
module sr_phase_timer
   import sr_ff_drv_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             run,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   assign zero = (count == '0);

   // Reload on state entry, otherwise count down and hold at zero (no wrap).
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of process ordering.
      if (rstn)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (run && !zero)
         count <= count - 1'b1;
   end

endmodule

// File: rtl/sr_ff_driver.sv
// Command-side driver for SR flip-flop cells: turns a valid/ready set/clear
// request into a bounded S or R pulse, then checks q/qbar feedback.
// Optional feature macro: SR_FF_DRV_SKIP_REDUNDANT_EN -- when defined, a
// command whose value already matches the cell feedback at accept skips the
// pulse and settle phases and goes straight to the check.
module sr_ff_driver
   import sr_ff_drv_pkg::*;
#(
   parameter int PULSE_W  = 2,
   parameter int SETTLE_W = 1
)(
   input  logic clk,
   input  logic rstn,
   input  logic req_valid,
   input  logic req_set,
   output logic req_ready,
   output logic S,
   output logic R,
   input  logic q_fb,
   input  logic qbar_fb,
   output logic done,
   output logic err
);

   localparam int PULSE_W_C  = clamp_width(PULSE_W, PULSE_W_MAX);
   localparam int SETTLE_W_C = clamp_width(SETTLE_W, SETTLE_W_MAX);
   localparam logic [CNT_W-1:0] PULSE_LOAD  = phase_load(PULSE_W_C);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = phase_load(SETTLE_W_C);

   state_t           state;
   state_t           state_nxt;
   logic             latched_set;
   logic             pulse_set;
   logic             accept;
   logic             fb_redundant;
   logic             mismatch;
   logic             err_q;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_run;
   logic             tmr_zero;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

`ifdef SR_FF_DRV_SKIP_REDUNDANT_EN
   assign fb_redundant = (q_fb == req_set) && (qbar_fb == ~req_set);
`else
   assign fb_redundant = 1'b0;
`endif

   // Both-equal feedback (0/0 or 1/1) never matches a legal pattern, so it
   // falls out of this comparison as a mismatch too.
   assign mismatch = (state == CHECK) &&
                     ((q_fb != latched_set) || (qbar_fb != ~latched_set));

   // Sticky error is visible in the CHECK cycle itself and held afterwards.
   assign err = err_q | mismatch;

   // The value driven during PULSE: the incoming request on the accept
   // cycle, the latched command afterwards.
   assign pulse_set = (state == IDLE) ? req_set : latched_set;

   sr_phase_timer u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (tmr_load),
      .load_val (tmr_val),
      .run      (tmr_run),
      .zero     (tmr_zero)
   );

   // Next-state and timer control; the timer reloads on every state entry.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      tmr_run   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               tmr_load = 1'b1;
               if (fb_redundant) begin
                  state_nxt = CHECK;
               end else begin
                  state_nxt = PULSE;
                  tmr_val   = PULSE_LOAD;
               end
            end
         end
         PULSE: begin
            tmr_run = 1'b1;
            if (tmr_zero) begin
               state_nxt = SETTLE;
               tmr_load  = 1'b1;
               tmr_val   = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            tmr_run = 1'b1;
            if (tmr_zero) begin
               state_nxt = CHECK;
               tmr_load  = 1'b1;
            end
         end
         CHECK: begin
            state_nxt = IDLE;
            tmr_load  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and command latch.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state       <= IDLE;
         latched_set <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept)
            latched_set <= req_set;
      end
   end

   // Registered strobes and done, decoded from the next state so they line
   // up with the state they belong to; S and R are mutually exclusive.
   always_ff @(posedge clk) begin
      if (rstn) begin
         S    <= 1'b0;
         R    <= 1'b0;
         done <= 1'b0;
      end else begin
         S    <= (state_nxt == PULSE) &&  pulse_set;
         R    <= (state_nxt == PULSE) && !pulse_set;
         done <= (state_nxt == CHECK);
      end
   end

   // Sticky feedback error, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rstn)
         err_q <= 1'b0;
      else if (mismatch)
         err_q <= 1'b1;
   end

endmodule

// File: tb/tb_sr_ff_driver.sv
// Self-checking bench for sr_ff_driver: a default instance (A) and a
// PULSE_W=3/SETTLE_W=2 instance (B), each driving a behavioural SR cell.
module tb_sr_ff_driver;

   logic clk  = 1'b0;
   logic rstn = 1'b1;

   logic rv_a = 1'b0, rs_a = 1'b0, rv_b = 1'b0, rs_b = 1'b0;
   logic rdy_a, s_a, r_a, done_a, err_a;
   logic rdy_b, s_b, r_b, done_b, err_b;
   logic q_a = 1'b0, q_b = 1'b0;
   logic stuck_a = 1'b0;
   logic qfb_a, qbfb_a, qfb_b, qbfb_b;

   int tests   = 0;
   int fails   = 0;
   int sr_viol = 0;

   typedef struct {
      int done_k;
      bit err;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   assign qfb_a  = stuck_a ? 1'b0 : q_a;
   assign qbfb_a = stuck_a ? 1'b1 : ~q_a;
   assign qfb_b  = q_b;
   assign qbfb_b = ~q_b;

   // Behavioural SR cells.
   always @(posedge clk) begin
      if (s_a) q_a <= 1'b1; else if (r_a) q_a <= 1'b0;
      if (s_b) q_b <= 1'b1; else if (r_b) q_b <= 1'b0;
   end

   // S and R must never be high together on either instance.
   always @(negedge clk)
      if ((s_a && r_a) || (s_b && r_b)) sr_viol++;

   sr_ff_driver u_dut_a (
      .clk(clk), .rstn(rstn), .req_valid(rv_a), .req_set(rs_a), .req_ready(rdy_a),
      .S(s_a), .R(r_a), .q_fb(qfb_a), .qbar_fb(qbfb_a), .done(done_a), .err(err_a)
   );

   sr_ff_driver #(.PULSE_W(3), .SETTLE_W(2)) u_dut_b (
      .clk(clk), .rstn(rstn), .req_valid(rv_b), .req_set(rs_b), .req_ready(rdy_b),
      .S(s_b), .R(r_b), .q_fb(qfb_b), .qbar_fb(qbfb_b), .done(done_b), .err(err_b)
   );

   function automatic logic rdy(input bit b); return b ? rdy_b  : rdy_a;  endfunction
   function automatic logic s_o(input bit b); return b ? s_b    : s_a;    endfunction
   function automatic logic r_o(input bit b); return b ? r_b    : r_a;    endfunction
   function automatic logic dn (input bit b); return b ? done_b : done_a; endfunction
   function automatic logic er (input bit b); return b ? err_b  : err_a;  endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one command and follow it cycle by cycle until ready returns.
   // k counts cycles after the accept edge (k=1 is the first cycle after it).
   task automatic do_cmd(input bit b, input bit set, input int p_in, input int sw_in,
                         input bit exp_err, input string tag);
      int   p, sw;
      bit   skip;
      exp_t e;
      p    = p_in;
      sw   = sw_in;
      skip = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 20 && !rdy(b); i++) @(negedge clk);
      check({tag, " ready before accept"}, rdy(b), 1'b1);
`ifdef SR_FF_DRV_SKIP_REDUNDANT_EN
      skip = b ? ((qfb_b == set) && (qbfb_b == !set))
               : ((qfb_a == set) && (qbfb_a == !set));
`endif
      if (skip) begin
         p  = 0;
         sw = 0;
      end
      e.done_k = p + sw + 1;
      e.err    = exp_err;
      sb.push_back(e);
      if (b) begin rv_b = 1'b1; rs_b = set; end
      else   begin rv_a = 1'b1; rs_a = set; end
      for (int k = 1; k <= p + sw + 2; k++) begin
         @(negedge clk);
         if (k == 1) begin rv_a = 1'b0; rv_b = 1'b0; end
         check({tag, " S"}, s_o(b), set && (k <= p));
         check({tag, " R"}, r_o(b), !set && (k <= p));
         check({tag, " ready"}, rdy(b), k == p + sw + 2);
         if (dn(b)) begin
            check({tag, " done has pending entry"}, sb.size(), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check({tag, " done cycle"}, k, e.done_k);
               check({tag, " err at done"}, er(b), e.err);
            end
         end
         if (k == p + sw + 2) check({tag, " err after done"}, er(b), exp_err);
      end
      check({tag, " done seen"}, sb.size(), 0);
      sb.delete();
   endtask

   int last_acc;
   int n_acc;
   bit flip;

   initial begin
      // 1: reset with a request pending.
      rstn = 1'b1; rv_a = 1'b1; rs_a = 1'b1; rv_b = 1'b1; rs_b = 1'b0;
      repeat (3) @(negedge clk);
      check("reset S_a", s_a, 1'b0);
      check("reset R_a", r_a, 1'b0);
      check("reset done_a", done_a, 1'b0);
      check("reset err_a", err_a, 1'b0);
      check("reset S_b", s_b, 1'b0);
      check("reset R_b", r_b, 1'b0);
      rstn = 1'b0; rv_a = 1'b0; rv_b = 1'b0;
      @(negedge clk);
      check("post-reset ready_a", rdy_a, 1'b1);
      check("post-reset ready_b", rdy_b, 1'b1);

      // 2: set and clear with defaults.
      do_cmd(1'b0, 1'b1, 2, 1, 1'b0, "set_a");
      do_cmd(1'b0, 1'b0, 2, 1, 1'b0, "clear_a");

      // 3: PULSE_W=3, SETTLE_W=2.
      do_cmd(1'b1, 1'b1, 3, 2, 1'b0, "set_b");
      do_cmd(1'b1, 1'b0, 3, 2, 1'b0, "clear_b");

      // 4: stuck cell, then a good command keeps the sticky error.
      stuck_a = 1'b1;
      do_cmd(1'b0, 1'b1, 2, 1, 1'b1, "stuck_set_a");
      stuck_a = 1'b0;
      do_cmd(1'b0, 1'b0, 2, 1, 1'b1, "sticky_clear_a");

      // 5: reset during the S pulse aborts the command.
      @(negedge clk);
      check("abort ready", rdy_a, 1'b1);
      rv_a = 1'b1; rs_a = 1'b1;
      @(negedge clk);
      rv_a = 1'b0;
      check("abort S before reset", s_a, 1'b1);
      rstn = 1'b1;
      @(negedge clk);
      check("abort S", s_a, 1'b0);
      check("abort R", r_a, 1'b0);
      check("abort done", done_a, 1'b0);
      check("abort err cleared", err_a, 1'b0);
      rstn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort no done", done_a, 1'b0);
         check("abort ready", rdy_a, 1'b1);
      end

      // 6: back-to-back requests with alternating value.
      last_acc = -1;
      n_acc    = 0;
      flip     = 1'b0;
      rs_a = ~q_a;
      rv_a = 1'b1;
      for (int i = 0; i < 22; i++) begin
         if (rdy_a) begin
            if (last_acc >= 0) check("b2b accept gap", i - last_acc, 5);
            last_acc = i;
            n_acc++;
            flip = 1'b1;
         end
         @(negedge clk);
         if (flip) begin
            rs_a = ~rs_a;
            flip = 1'b0;
         end
      end
      rv_a = 1'b0;
      check("b2b accept count", n_acc, 5);
      repeat (6) @(negedge clk);
      check("b2b err", err_a, 1'b0);

      // 6b: set a cell that is already set (skipped when the feature is built in).
      do_cmd(1'b0, 1'b1, 2, 1, 1'b0, "prime_set_a");
      do_cmd(1'b0, 1'b1, 2, 1, 1'b0, "redundant_set_a");

      check("S&R exclusive", sr_viol, 0);
      check("final err_b", err_b, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
